button_debounce: RTL and testbench
==================================

# button_debounce

Debounces the board's active-low push buttons and hands clean, glitch-free levels to the downstream LED data-select mux. Each raw button is synchronised into the clock domain and filtered by a per-channel stability counter. Output polarity is unchanged (still active-low), so the mux's existing inversion keeps working. An optional one-cycle press strobe per button is available to later counter/menu stages.

## Interface
- `WIDTH`, default 2: number of button channels; matches the mux `sel` width.
- `CNT_MAX`, default 500000: consecutive cycles a new level must hold before it is accepted (10 ms at 50 MHz); legal range ≥ 2.
- `clk` input 1: single system clock; all state is on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `btn_n` input WIDTH: raw push-button pins, active-low, asynchronous to `clk`.
- `sel_n` output WIDTH: debounced button levels, active-low; feeds the mux `sel`.
- `press` output WIDTH: one-cycle strobe per channel on an accepted press (1→0 transition of `sel_n`).

## Operation
- Per channel: 2-flop synchroniser `s1 → s2`, stable register `sel_n[i]`, counter `cnt[i]` of width `$clog2(CNT_MAX)`.
- Reset: `s1`, `s2` and `sel_n` go to all ones (released). `cnt` goes to 0 and `press` to 0.
- Each cycle, per channel:
  - `s2 == sel_n[i]`: `cnt` ← 0.
  - `s2 != sel_n[i]` and `cnt < CNT_MAX-1`: `cnt` ← `cnt+1`.
  - `s2 != sel_n[i]` and `cnt == CNT_MAX-1`: `sel_n[i]` ← `s2` and `cnt` ← 0.
- Any return of `s2` to the stable value before acceptance clears `cnt`. A glitch shorter than `CNT_MAX` cycles never reaches `sel_n`.
- `cnt` never wraps. It saturates logically because acceptance resets it.
- Channels are fully independent. Simultaneous transitions on several buttons are each accepted on their own schedule.
- Release (0→1) is filtered identically to press.

## Timing
- Let the raw pin settle at edge E0, i.e. first sampled by `s1` at E0. Then:
  - `s2` differs from E1.
  - `sel_n` updates at edge E1+`CNT_MAX`.
  - Total latency is `CNT_MAX`+1 edges.
- `press[i]` is registered. It is high for exactly the one cycle following the edge on which `sel_n[i]` goes 1→0, and is 0 otherwise.
- Reset asserted mid-count: all counters clear immediately and outputs return to released. A press in progress is lost. The level is re-qualified from scratch after reset deasserts.
- An input held low through reset deassertion produces an accepted press `CNT_MAX`+1 edges after deassert, with `press` asserted.

## Configuration
- `BUTTON_DEBOUNCE_PRESS_EN`:
  - When defined, the press-strobe logic and its register are compiled in as described above.
  - When undefined, `press` is tied to all zeros, no strobe flops exist, and `sel_n` behaviour is identical.

## Structure
- Shared package `debounce_pkg`:
  - `DEBOUNCE_CNT_MAX_DEFAULT` = 500000.
  - `DEBOUNCE_CNT_MAX_SIM` = 4.
  - Localparam-style helper for the counter width.
- Natural sub-module `debounce_bit`:
  - Contains the synchroniser, counter, stable register and optional strobe for one channel.
  - `button_debounce` instantiates it `WIDTH` times in a generate loop.

## Test plan
All scenarios use `CNT_MAX`=4 and `WIDTH`=2.
- Reset behaviour: assert `rst` with `btn_n`=2'b00 → `sel_n`=2'b11 and `press`=2'b00 while in reset and on the first cycle after release.
- Clean press: drive `btn_n[0]` 1→0 at edge E0 and hold → `sel_n[0]`=0 at E5. `press`=2'b01 for exactly one cycle after E5. `sel_n[1]` stays 1.
- Bounce rejection: toggle `btn_n[1]` low for 3 cycles, high for 1, repeated 5 times, then high → `sel_n[1]` never leaves 1 and `press[1]` is never asserted.
- Independent channels: press `btn_n[0]` at E0 and `btn_n[1]` at E2 → `sel_n[0]` falls at E5 and `sel_n[1]` at E7, each with its own single `press` pulse.
- Mid-count reset: press `btn_n[0]` and pulse `rst` at E3 while still held → `sel_n[0]`=1 through reset, then falls 5 edges after deassert with one `press` pulse.
- Macro off: repeat the clean-press scenario with `BUTTON_DEBOUNCE_PRESS_EN` undefined → `sel_n` timing identical and `press` constantly 2'b00.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// ----------------------------------------------------------------------------
// debounce_pkg
// Shared constants and helpers for the push-button debouncer.
//   DEBOUNCE_CNT_MAX_DEFAULT : hold time in cycles for hardware (10 ms @ 50 MHz)
//   DEBOUNCE_CNT_MAX_SIM     : short hold time used in simulation
//   cnt_width()              : width of the per-channel stability counter
// ----------------------------------------------------------------------------
package debounce_pkg;

   localparam int DEBOUNCE_CNT_MAX_DEFAULT = 500000;
   localparam int DEBOUNCE_CNT_MAX_SIM     = 4;

   // Buttons are active-low, so the idle/released level is 1.
   localparam logic LVL_RELEASED = 1'b1;

   // Counter only has to reach cnt_max-1, so $clog2(cnt_max) bits suffice;
   // never narrower than one bit.
   function automatic int cnt_width(input int cnt_max);
      int w;
      w = $clog2(cnt_max);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/button_debounce_if.sv
// ----------------------------------------------------------------------------
// button_debounce_if
// Bundles the raw and debounced button signals.
//   btn_n : raw active-low pins (driven by the board side)
//   sel_n : debounced active-low levels (driven by the debouncer)
//   press : one-cycle press strobes (driven by the debouncer)
// Modports: master = board/consumer side, slave = debouncer side.
// ----------------------------------------------------------------------------
interface button_debounce_if #(
   parameter int WIDTH = 2
);
   logic [WIDTH-1:0] btn_n;
   logic [WIDTH-1:0] sel_n;
   logic [WIDTH-1:0] press;

   modport master (output btn_n, input sel_n, input press);
   modport slave  (input btn_n, output sel_n, output press);
endinterface

// File: rtl/button_debounce_bit.sv
// ----------------------------------------------------------------------------
// debounce_bit
// One debounce channel: 2-flop synchroniser, stability counter, stable level
// register and (optionally) a registered press strobe.
//   clk   : system clock
//   rst   : asynchronous active-high reset
//   btn_n : raw active-low button pin (asynchronous)
//   sel_n : debounced active-low level
//   press : one-cycle strobe on an accepted 1->0 transition of sel_n
// Optional feature macro: BUTTON_DEBOUNCE_PRESS_EN (press strobe logic);
// without it press is tied to 0.
// ----------------------------------------------------------------------------
module debounce_bit
   import debounce_pkg::*;
#(
   parameter int CNT_MAX = DEBOUNCE_CNT_MAX_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic sel_n,
   output logic press
);

   localparam int              CW       = cnt_width(CNT_MAX);
   localparam logic [CW-1:0]   CNT_LAST = CW'(CNT_MAX - 1);

   logic          s1_reg;
   logic          s2_reg;
   logic          sel_reg;
   logic [CW-1:0] cnt_reg;
   logic          accept;

   // The new level has differed for CNT_MAX consecutive samples.
   assign accept = (s2_reg != sel_reg) && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_reg  <= LVL_RELEASED;
         s2_reg  <= LVL_RELEASED;
         sel_reg <= LVL_RELEASED;
         cnt_reg <= '0;
      end else begin
         s1_reg <= btn_n;
         s2_reg <= s1_reg;
         if (s2_reg == sel_reg) begin
            // Any return to the stable level restarts qualification.
            cnt_reg <= '0;
         end else if (accept) begin
            sel_reg <= s2_reg;
            cnt_reg <= '0;
         end else begin
            // Cannot overflow: acceptance at CNT_LAST clears the counter.
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign sel_n = sel_reg;

`ifdef BUTTON_DEBOUNCE_PRESS_EN
   logic press_reg;

   // Rises on the same edge that sel_n falls, so it is high for exactly
   // the cycle following that edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         press_reg <= 1'b0;
      end else begin
         press_reg <= accept & ~s2_reg;
      end
   end

   assign press = press_reg;
`else
   assign press = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// ----------------------------------------------------------------------------
// button_debounce
// Debounces WIDTH active-low push buttons for the LED data-select mux.
// Output polarity is preserved (active-low).
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   btns : button_debounce_if.slave (btn_n in, sel_n / press out)
// Parameters: WIDTH (channels), CNT_MAX (hold cycles, >= 2).
// Optional feature macro: BUTTON_DEBOUNCE_PRESS_EN (press strobes).
// ----------------------------------------------------------------------------
module button_debounce
   import debounce_pkg::*;
#(
   parameter int WIDTH   = 2,
   parameter int CNT_MAX = DEBOUNCE_CNT_MAX_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   button_debounce_if.slave     btns
);

   logic [WIDTH-1:0] sel_vec;
   logic [WIDTH-1:0] press_vec;

   // Channels are fully independent; each runs its own qualification.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
         debounce_bit #(
            .CNT_MAX (CNT_MAX)
         ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .btn_n (btns.btn_n[gi]),
            .sel_n (sel_vec[gi]),
            .press (press_vec[gi])
         );
      end
   endgenerate

   assign btns.sel_n = sel_vec;
   assign btns.press = press_vec;

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;
   import debounce_pkg::*;

   localparam int W  = 2;
   localparam int CM = DEBOUNCE_CNT_MAX_SIM;
`ifdef BUTTON_DEBOUNCE_PRESS_EN
   localparam logic [1:0] PMASK = 2'b11;
`else
   localparam logic [1:0] PMASK = 2'b00;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   button_debounce_if #(.WIDTH(W)) bif ();

   button_debounce #(
      .WIDTH   (W),
      .CNT_MAX (CM)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .btns (bif.slave)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // ---------------- reference model ----------------
   // A new level is accepted once the synchronised input (raw delayed by two
   // samples) has shown the opposite of the current output for CM samples in
   // a row since reset.
   logic [1:0] raw_q[$];
   logic [1:0] win[$];
   logic [1:0] m_sel;
   logic [1:0] m_press;

   function automatic void model_reset();
      raw_q.delete();
      raw_q.push_back(2'b11);
      raw_q.push_back(2'b11);
      win.delete();
      m_sel   = 2'b11;
      m_press = 2'b00;
   endfunction

   function automatic void model_edge(input logic [1:0] b);
      logic [1:0] smp;
      logic       alldiff;
      smp = raw_q.pop_front();
      raw_q.push_back(b);
      win.push_back(smp);
      if (win.size() > CM) void'(win.pop_front());
      m_press = 2'b00;
      for (int ch = 0; ch < W; ch++) begin
         if (win.size() == CM) begin
            alldiff = 1'b1;
            for (int k = 0; k < win.size(); k++)
               if (win[k][ch] == m_sel[ch]) alldiff = 1'b0;
            if (alldiff) begin
               m_sel[ch] = ~m_sel[ch];
               if (m_sel[ch] == 1'b0) m_press[ch] = 1'b1;
            end
         end
      end
   endfunction

   // ---------------- check helpers ----------------
   task automatic check2(input string name, input logic [1:0] act, input logic [1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %b want %b", name, cyc, act, req);
      end
   endtask

   // One transaction: apply inputs, take one clock edge, compare against model.
   task automatic cycle(input logic r, input logic [1:0] b);
      rst       = r;
      bif.btn_n = b;
      if (r) model_reset();
      @(posedge clk);
      if (r) model_reset();
      else   model_edge(b);
      #1;
      cyc++;
      $display("cyc %0d rst=%b btn_n=%b sel_n=%b press=%b", cyc, r, b, bif.sel_n, bif.press);
      check2("model_sel", bif.sel_n, m_sel);
      check2("model_press", bif.press, m_press & PMASK);
   endtask

   typedef struct {
      logic       r;
      logic [1:0] b;
      logic [1:0] s;
      logic [1:0] p;
   } vec_t;

   vec_t tbl[20];
   logic [1:0] ind_sel[9]   = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b00};
   logic [1:0] ind_press[9] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

   initial begin
      logic [1:0] rb;
      logic       rr;

      // Reset with buttons held, then clean press and release of channel 0.
      tbl[0] = '{1'b1, 2'b00, 2'b11, 2'b00};
      tbl[1] = '{1'b0, 2'b00, 2'b11, 2'b00};
      for (int i = 2;  i <= 5;  i++) tbl[i] = '{1'b0, 2'b11, 2'b11, 2'b00};
      for (int i = 6;  i <= 10; i++) tbl[i] = '{1'b0, 2'b10, 2'b11, 2'b00};
      tbl[11] = '{1'b0, 2'b10, 2'b10, 2'b01};
      tbl[12] = '{1'b0, 2'b10, 2'b10, 2'b00};
      for (int i = 13; i <= 17; i++) tbl[i] = '{1'b0, 2'b11, 2'b10, 2'b00};
      tbl[18] = '{1'b0, 2'b11, 2'b11, 2'b00};
      tbl[19] = '{1'b0, 2'b11, 2'b11, 2'b00};

      rst       = 1'b1;
      bif.btn_n = 2'b00;
      model_reset();
      #2;
      check2("reset_sel", bif.sel_n, 2'b11);
      check2("reset_press", bif.press, 2'b00);

      for (int i = 0; i < 20; i++) begin
         cycle(tbl[i].r, tbl[i].b);
         check2($sformatf("tbl%0d_sel", i), bif.sel_n, tbl[i].s);
         check2($sformatf("tbl%0d_press", i), bif.press, tbl[i].p & PMASK);
      end

      // Bounce rejection on channel 1.
      for (int rep = 0; rep < 5; rep++) begin
         for (int k = 0; k < 4; k++) begin
            cycle(1'b0, (k < 3) ? 2'b01 : 2'b11);
            check2("bounce_sel1", {1'b0, bif.sel_n[1]}, 2'b01);
            check2("bounce_press1", {1'b0, bif.press[1]}, 2'b00);
         end
      end
      for (int k = 0; k < 6; k++) begin
         cycle(1'b0, 2'b11);
         check2("bounce_sel1", {1'b0, bif.sel_n[1]}, 2'b01);
      end

      // Independent channels: ch0 at E0, ch1 at E2.
      for (int i = 0; i < 9; i++) begin
         cycle(1'b0, (i < 2) ? 2'b10 : 2'b00);
         check2($sformatf("indep%0d_sel", i), bif.sel_n, ind_sel[i]);
         check2($sformatf("indep%0d_press", i), bif.press, ind_press[i] & PMASK);
      end
      for (int k = 0; k < 8; k++) cycle(1'b0, 2'b11);

      // Mid-count reset at E3 with ch0 held low.
      for (int i = 0; i <= 10; i++) begin
         cycle(i == 3, 2'b10);
         check2($sformatf("midrst%0d_sel", i), bif.sel_n, (i >= 9) ? 2'b10 : 2'b11);
         check2($sformatf("midrst%0d_press", i), bif.press, ((i == 9) ? 2'b01 : 2'b00) & PMASK);
      end
      for (int k = 0; k < 8; k++) cycle(1'b0, 2'b11);

      // Randomised bursty stimulus against the model.
      rb = 2'b11;
      for (int n = 0; n < 300; n++) begin
         for (int ch = 0; ch < W; ch++)
            if ($urandom_range(0, 3) == 0) rb[ch] = ~rb[ch];
         rr = ($urandom_range(0, 99) == 0);
         cycle(rr, rb);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
